wishbone_ctrl_bridge: RTL and testbench



---
 rtl/wishbone_ctrl_bridge.sv | 134 +++++++++++++
 tb/tb_wishbone_ctrl_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_ctrl_bridge.sv
// wishbone_ctrl_bridge: byte-command stream to single Wishbone cycles.
// Sole bus master on the 8-bit Wishbone bus; read data returns as a byte.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rx_data/valid     command/data bytes in; rx_ready accepts them
//   tx_data/valid     read-response byte out; tx_ready accepts it
//   wb_stb/we/adr     Wishbone cycle control driven by this controller
//   wb_dat_c          write data to the peripheral
//   wb_dat_p, wb_ack  read data and acknowledge from the peripheral
//   err               one-cycle pulse when a bus cycle times out
//
// Command byte: bit7 = write, bits3:0 = address, bits6:4 reserved.
// A write command is followed by exactly one data byte.

module wishbone_ctrl_bridge #(
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] ERR_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [3:0] wb_adr,
    output logic [7:0] wb_dat_c,
    input  logic [7:0] wb_dat_p,
    input  logic       wb_ack,
    output logic       err
);

    // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_BUS  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rx_fire;
    logic          timeout_hit;
    logic          unused_rsvd;

    // Reserved command bits carry no meaning.
    assign unused_rsvd = ^rx_data[6:4];

    assign rx_ready = !rst && (state == S_IDLE || state == S_DATA);
    assign rx_fire  = rx_valid && rx_ready;

    // cnt holds the number of completed stb cycles without an ack,
    // so this fires on the TIMEOUT-th stb cycle.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= 4'h0;
            wb_dat_c <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        wb_we  <= rx_data[7];
                        wb_adr <= rx_data[3:0];
                        if (rx_data[7]) begin
                            state <= S_DATA;
                        end else begin
                            state  <= S_BUS;
                            wb_stb <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        wb_dat_c <= rx_data;
                        state    <= S_BUS;
                        wb_stb   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                S_BUS: begin
                    // Ack takes priority over a same-cycle timeout.
                    if (wb_ack) begin
                        wb_stb <= 1'b0;
                        if (wb_we) begin
                            state <= S_IDLE;
                        end else begin
                            tx_data  <= wb_dat_p;
                            tx_valid <= 1'b1;
                            state    <= S_RESP;
                        end
                    end else if (timeout_hit) begin
                        wb_stb <= 1'b0;
                        err    <= 1'b1;
                        if (wb_we) begin
                            state <= S_IDLE;
                        end else begin
                            tx_data  <= ERR_BYTE;
                            tx_valid <= 1'b1;
                            state    <= S_RESP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_ctrl_bridge.sv
// tb_wishbone_ctrl_bridge: scoreboard bench for wishbone_ctrl_bridge.
// Driver pushes expected bus cycles and tx bytes; monitor pops them.

module tb_wishbone_ctrl_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       wb_stb;
    logic       wb_we;
    logic [3:0] wb_adr;
    logic [7:0] wb_dat_c;
    logic [7:0] wb_dat_p = 8'h00;
    logic       wb_ack = 1'b0;
    logic       err;

    wishbone_ctrl_bridge #(
        .TIMEOUT  (4),
        .ERR_BYTE (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_c (wb_dat_c),
        .wb_dat_p (wb_dat_p),
        .wb_ack   (wb_ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;
        int         len;
        logic       err;
    } bus_rec_t;

    bus_rec_t   bus_q[$];
    logic [7:0] tx_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peripheral model: acks on the ack_at-th stb cycle (0 = never).
    int         ack_at    = 0;
    logic [7:0] rd_data   = 8'h00;
    logic       stray_ack = 1'b0;
    int         k         = 0;

    always begin
        @(posedge clk);
        #2;
        if (wb_stb === 1'b1) k = k + 1;
        else k = 0;
        wb_ack = stray_ack ||
            (wb_stb === 1'b1 && ack_at != 0 && k == ack_at);
        wb_dat_p = rd_data;
    end

    // Monitor.
    logic       mon_en   = 1'b0;
    logic       prev_stb = 1'b0;
    logic       prev_txv = 1'b0;
    logic       prev_txr = 1'b0;
    logic [7:0] prev_txd = 8'h00;
    int         run_len  = 0;
    logic       cap_we;
    logic [3:0] cap_adr;
    logic [7:0] cap_dat;
    logic       stable;
    bus_rec_t   me;
    logic [7:0] mt;

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_stb) begin
                if (!prev_stb) begin
                    run_len = 1;
                    cap_we  = wb_we;
                    cap_adr = wb_adr;
                    cap_dat = wb_dat_c;
                    stable  = 1'b1;
                end else begin
                    run_len++;
                    if (wb_we !== cap_we || wb_adr !== cap_adr ||
                        wb_dat_c !== cap_dat)
                        stable = 1'b0;
                end
            end else if (prev_stb) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_extra: got adr %0h expected none",
                             cap_adr);
                end else begin
                    me = bus_q.pop_front();
                    chk("bus_we", cap_we, me.we);
                    chk("bus_adr", cap_adr, me.adr);
                    if (me.we) chk("bus_dat", cap_dat, me.dat);
                    chk("bus_len", run_len, me.len);
                    chk("bus_err", err, me.err);
                    chk("bus_stable", stable, 1);
                end
            end
            if (err && !(prev_stb && !wb_stb)) begin
                checks++;
                failures++;
                $display("FAIL err_stray: got 1 expected 0");
            end
            if (tx_valid && prev_txv && !prev_txr)
                chk("tx_hold", tx_data, prev_txd);
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_extra: got %0h expected none",
                             tx_data);
                end else begin
                    mt = tx_q.pop_front();
                    chk("tx_data", tx_data, mt);
                end
            end
            prev_stb = wb_stb;
            prev_txv = tx_valid;
            prev_txr = tx_ready;
            prev_txd = tx_data;
        end
    end

    task automatic push_bus(logic we, logic [3:0] adr, logic [7:0] dat,
                            int len, logic e);
        bus_rec_t r;
        r.we  = we;
        r.adr = adr;
        r.dat = dat;
        r.len = len;
        r.err = e;
        bus_q.push_back(r);
    endtask

    // Returns at cycle 1 (+1) relative to the transfer edge.
    task automatic send(logic [7:0] b);
        bit ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no rx_ready expected 1");
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready && !tx_valid) begin
                ok = 1;
                break;
            end
        end
        chk("wait_idle", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat_c", wb_dat_c, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_ready", rx_ready, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Write, zero-wait.
        ack_at = 1;
        push_bus(1'b1, 4'h3, 8'h5A, 1, 1'b0);
        send(8'h83);
        send(8'h5A);
        @(negedge clk);
        chk("wr_rx_ready_c1", rx_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wr_rx_ready_c2", rx_ready, 1);
        @(posedge clk);
        #1;

        // Read, 3 wait states (ack lands on the last timeout cycle).
        ack_at  = 4;
        rd_data = 8'hC3;
        push_bus(1'b0, 4'h7, 8'h00, 4, 1'b0);
        tx_q.push_back(8'hC3);
        send(8'h07);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("rd_txv_lat", tx_valid, (i == 5));
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // Tx backpressure.
        tx_ready = 1'b0;
        ack_at   = 1;
        rd_data  = 8'h11;
        push_bus(1'b0, 4'h1, 8'h00, 1, 1'b0);
        tx_q.push_back(8'h11);
        send(8'h01);
        rx_data  = 8'h81;
        rx_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("bp_rx_ready", rx_ready, 0);
            if (i >= 2) chk("bp_txv", tx_valid, 1);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("bp_txv_final", tx_valid, 1);
        chk("bp_rx_ready_final", rx_ready, 0);
        wait_idle();

        // Timeout read, then timeout write.
        ack_at = 0;
        push_bus(1'b0, 4'h2, 8'h00, 4, 1'b1);
        tx_q.push_back(8'hFF);
        send(8'h02);
        wait_idle();
        push_bus(1'b1, 4'hA, 8'h77, 4, 1'b1);
        send(8'h8A);
        send(8'h77);
        wait_idle();

        // Reset during the 2nd stb cycle of a read.
        push_bus(1'b0, 4'h5, 8'h00, 2, 1'b0);
        send(8'h05);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_stb", wb_stb, 0);
        chk("mid_rst_txv", tx_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_rx_ready", rx_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ack_at  = 2;
        rd_data = 8'h9E;
        push_bus(1'b0, 4'hC, 8'h00, 2, 1'b0);
        tx_q.push_back(8'h9E);
        send(8'h0C);
        wait_idle();

        // Ack/timeout collision, then stray ack in IDLE.
        ack_at  = 4;
        rd_data = 8'h3C;
        push_bus(1'b0, 4'h9, 8'h00, 4, 1'b0);
        tx_q.push_back(8'h3C);
        send(8'h09);
        wait_idle();
        stray_ack = 1'b1;
        rd_data   = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_stb", wb_stb, 0);
            chk("stray_txv", tx_valid, 0);
            chk("stray_err", err, 0);
            chk("stray_rx_ready", rx_ready, 1);
            chk("stray_tx_data", tx_data, 8'h3C);
            @(posedge clk);
            #1;
        end
        stray_ack = 1'b0;
        ack_at    = 2;
        push_bus(1'b1, 4'hF, 8'hC4, 2, 1'b0);
        send(8'h8F);
        send(8'hC4);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
